// File: rtl/adder_pipe_n.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe_n
// Purpose  : WIDTH-bit add/subtract split into STAGES carry-chained chunks,
//            one chunk per pipeline stage, with valid/ready flow control.
// Revision : 1.0  initial release
// ============================================================================
module adder_pipe_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("adder_pipe_n: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end
  endgenerate

  // Per-stage state: stage k holds result chunks 0..k plus the skewed operands.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic              ovf_q;
  logic              ovf_d;

  // Stage inputs: index 0 is the port side, index k>0 is stage k-1's registers.
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;
  logic [CW:0]       chunk [STAGES];

  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic              msb_carry;
  logic              advance;

  always_comb begin
    b_eff     = sub ? ~b : b;
    c0        = cin ^ sub;
    a_src     = '{default: '0};
    b_src     = '{default: '0};
    s_src     = '{default: '0};
    c_src     = '0;
    v_src     = '0;
    chunk     = '{default: '0};
    sum_d     = '{default: '0};
    carry_d   = '0;

    a_src[0]  = a;
    b_src[0]  = b_eff;
    c_src[0]  = c0;
    v_src[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = carry_q[k-1];
      v_src[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_src[k][k*CW +: CW]}
               + {1'b0, b_src[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_src[k]};
      sum_d[k]               = s_src[k];
      sum_d[k][k*CW +: CW]   = chunk[k][CW-1:0];
      carry_d[k]             = chunk[k][CW];
    end

    // Carry into the MSB recovered from the MSB's own sum bit.
    msb_carry = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
              ^ sum_d[STAGES-1][WIDTH-1];
    ovf_d     = msb_carry ^ carry_d[STAGES-1];
  end

  assign advance   = ~valid_q[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q <= v_src;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipe_n
// Purpose  : Directed and scoreboarded checks of adder_pipe_n (32/4 and 8/1).
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_pipe_n;

  logic        clk;
  logic        rst;
  logic        iv32, ir32, ov32, or32, cin32, sub32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;
  logic        iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int          n_tests;
  int          n_fail;
  int          n_out;
  logic        mon_en;
  logic        rand_rdy;
  logic [33:0] sb_q [$];

  adder_pipe_n #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(cout32), .ovf(ovf32)
  );

  adder_pipe_n #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum}; signed overflow from the carry into bit 31.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
    logic [31:0] be;
    logic [32:0] full;
    logic [31:0] low;
    be   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, be} + {32'd0, ci ^ s};
    low  = {1'b0, x[30:0]} + {1'b0, be[30:0]} + {31'd0, ci ^ s};
    return {low[31] ^ full[32], full[32], full[31:0]};
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (iv32 && ir32) sb_q.push_back(model32(a32, b32, cin32, sub32));
      if (ov32 && or32) begin
        if (sb_q.size() == 0) begin
          check("sb_extra_result", 64'(ov32), 64'(0));
        end else begin
          check("sb_data", 64'({ovf32, cout32, sum32}), 64'(sb_q.pop_front()));
          n_out++;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) or32 = 1'($urandom_range(0, 1));
  end

  task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    int waited;
    a32 = x; b32 = y; cin32 = ci; sub32 = s; iv32 = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!ir32 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ir32) check("send_timeout", 64'(ir32), 64'(1));
    @(posedge clk);
    #1;
    iv32 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_pending", 64'(sb_q.size()), 64'(0));
  endtask

  // One operation into an idle pipe; result expected after the 4th edge.
  task automatic single32(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo);
    a32 = x; b32 = y; cin32 = ci; sub32 = s; iv32 = 1'b1; or32 = 1'b1;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_early_valid"}, 64'(ov32), 64'(0));
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(ov32), 64'(1));
    check({tag, "_sum"}, 64'(sum32), 64'(es));
    check({tag, "_cout"}, 64'(cout32), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf32), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic single8(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic s, input logic [7:0] es,
                         input logic ec, input logic eo);
    a8 = x; b8 = y; cin8 = ci; sub8 = s; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    check({tag, "_valid"}, 64'(ov8), 64'(1));
    check({tag, "_sum"}, 64'(sum8), 64'(es));
    check({tag, "_cout"}, 64'(cout8), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf8), 64'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt_v;
    int          start_out;
    logic        saw_nr;
    logic [31:0] hx, hy;
    logic        hc, hs;

    n_tests = 0; n_fail = 0; n_out = 0; mon_en = 1'b0; rand_rdy = 1'b0;
    rst = 1'b1;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;

    #3;
    check("rst_out_valid", 64'(ov32), 64'(0));
    check("rst_sum", 64'(sum32), 64'(0));
    check("rst_cout_ovf", 64'({cout32, ovf32}), 64'(0));
    check("rst_in_ready", 64'(ir32), 64'(1));
    check("rst8_out_valid", 64'(ov8), 64'(0));
    check("rst8_in_ready", 64'(ir8), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    single32("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single32("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single32("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single32("sub_borrow", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);

    // Back-to-back stream with the scoreboard.
    mon_en = 1'b1; saw_nr = 1'b0; cnt_v = 0; start_out = n_out; or32 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      iv32 = 1'b1;
      @(negedge clk);
      if (!ir32) saw_nr = 1'b1;
      if (ov32) cnt_v++;
      @(posedge clk);
      #1;
    end
    iv32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ov32) cnt_v++;
      @(posedge clk);
      #1;
    end
    check("stream_valid_cycles", 64'(cnt_v), 64'(16));
    check("stream_in_ready_drop", 64'(saw_nr), 64'(0));
    check("stream_count", 64'(n_out - start_out), 64'(16));
    @(negedge clk);
    check("stream_tail_idle", 64'(ov32), 64'(0));
    @(posedge clk);
    #1;

    // Backpressure: fill the pipe, stall five cycles, then drain.
    start_out = n_out; or32 = 1'b0;
    for (int i = 0; i < 4; i++) send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    hx = $urandom; hy = $urandom; hc = 1'b1; hs = 1'b0;
    a32 = hx; b32 = hy; cin32 = hc; sub32 = hs; iv32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(ir32), 64'(0));
      check("bp_out_valid", 64'(ov32), 64'(1));
      check("bp_hold", 64'({ovf32, cout32, sum32}), 64'(sb_q[0]));
      @(posedge clk);
      #1;
    end
    or32 = 1'b1;
    send32(hx, hy, hc, hs);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("bp_count", 64'(n_out - start_out), 64'(5));

    // Bubbles with random downstream readiness.
    start_out = n_out; rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
    end
    wait_drain();
    rand_rdy = 1'b0;
    or32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bubble_count", 64'(n_out - start_out), 64'(12));
    mon_en = 1'b0;

    // Asynchronous reset with three operations in flight.
    or32 = 1'b1; iv32 = 1'b1; cin32 = 1'b0; sub32 = 1'b0;
    a32 = 32'hF000_0000; b32 = 32'h2000_0000;
    @(posedge clk); #1;
    a32 = 32'h0000_0011; b32 = 32'h0000_0022;
    @(posedge clk); #1;
    a32 = 32'h0000_0033; b32 = 32'h0000_0044;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_pre_valid", 64'(ov32), 64'(1));
    check("rst_mid_pre_sum", 64'({cout32, sum32}), 64'({1'b1, 32'h1000_0000}));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(ov32), 64'(0));
    check("rst_mid_sum", 64'(sum32), 64'(0));
    check("rst_mid_cout", 64'(cout32), 64'(0));
    check("rst_mid_in_ready", 64'(ir32), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    single32("post_rst", 32'd2, 32'd3, 1'b1, 1'b0, 32'd6, 1'b0, 1'b0);
    check("post_rst_no_stale", 64'(ov32), 64'(0));

    // Single-stage 8-bit instance.
    single8("s1_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("s1_drained", 64'(ov8), 64'(0));
    single8("s1_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    single8("s1_sub", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h55;
    @(posedge clk); #1;
    check("s1_bp_in_ready", 64'(ir8), 64'(0));
    check("s1_bp_hold", 64'({ov8, sum8}), 64'({1'b1, 8'h30}));
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check("s1_bp_release", 64'(ov8), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_pipe_n.md
Name: adder_pipe_n

Overview:
Parameterised, pipelined successor to the combinational n-bit adder. Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per pipeline stage. Adds a valid/ready handshake, a subtract mode and signed overflow. Used in datapaths where a single-cycle WIDTH-bit carry chain misses timing.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES (elaboration error otherwise).
STAGES, 4, pipeline depth, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  input operands valid.
in_ready  output  1  block can accept the input this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0: sum = a + b + cin; 1: sum = a - b - cin.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry-out of the MSB (for sub: 1 = no borrow).
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic: b_eff = sub ? ~b : b; c0 = cin ^ sub; {cout, sum} = a + b_eff + c0 at (WIDTH+1) bits. ovf = carry into bit WIDTH-1 XOR cout.
- Stage k (0..STAGES-1) registers chunk k: a[k*CW +: CW] + b_eff chunk + carry from stage k-1 (c0 for k=0). It also registers that chunk's carry-out. Lower, already-computed sum chunks move forward unchanged. Higher, not-yet-used a/b_eff chunks are delayed in skew registers.
- The last stage also registers the carry into bit WIDTH-1, for ovf.
- sub is applied at the input (b inverted, c0 formed) before stage 0. No mode bit is carried down the pipe.
- Each stage has a valid bit. out_valid = valid bit of the last stage. sum/cout/ovf are driven directly from last-stage registers, with no output logic after the register.
- Flow control is a global stall: advance = !out_valid | out_ready; in_ready = advance (combinational).
- On advance, every stage loads from its predecessor, and stage 0 loads valid = in_valid.
- When advance = 0, all stages hold their contents, including bubbles. Bubbles are not collapsed.
- A transfer in occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
- Latency: an input accepted at edge t appears with out_valid = 1 after edge t+STAGES-1, provided no stall intervenes. Each stalled cycle adds one cycle of latency.
- Throughput: one result per cycle while out_ready stays high.
- Simultaneous transfer in and out in the same cycle is legal and is the steady state.
- Outputs are stable while out_valid & !out_ready: sum, cout and ovf must not change until accepted.
- Inputs are sampled only on a transfer in. a, b, cin and sub are don't-care when in_valid = 0.
- Reset (asynchronous assert, may occur mid-operation): all valid bits clear to 0, so out_valid = 0 immediately. sum = 0, cout = 0, ovf = 0; all data and skew registers clear to 0. In-flight operations are discarded.
- in_ready = 1 while rst is high and after rst is released, because out_valid = 0.
- STAGES = 1 degenerates to a registered adder with 1-cycle latency and the same handshake.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1; a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 edges: sum=0x00000000, cout=1, ovf=0 (carry rippled across all chunks).
- Sub mode: a=0x00000005, b=0x00000007, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-to-back stream of 16 random (a, b, cin, sub) with out_ready=1 -> 16 consecutive out_valid cycles, in order, each matching the reference model; in_ready constantly 1.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, and sum/cout/ovf unchanged throughout. Release -> results drain in order, with no loss and no duplication.
- Bubbles: drive in_valid alternating 1/0 with out_ready random (50%) -> output sequence equals input sequence; out_valid never asserts for a bubble.
- Reset mid-stream: assert rst while 3 operations are in flight -> out_valid=0 and sum=0 immediately (asynchronous). After release, a new op 2+3 (cin=1) yields sum=6 after 4 edges, and no stale results appear. Repeat with STAGES=1 and WIDTH=8: 0xFF+0x01 -> 0x00, cout=1, after 1 edge.
